// File: rtl/calc_pkg.sv
// Shared calculator types: operand/result word, ALU operation codes and the
// arbiter state encoding used by alu_arbiter.
package calc_pkg;

    localparam int NumW = 16;

    typedef logic [NumW-1:0] num_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    // Round-robin successor of idx among n ports, wrapping n-1 -> 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first valid index found when
// searching upward from ptr_i with wrap-around.
module rr_picker #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] valid_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_o,
    output logic         grant_valid_o
);

    int         idx_s;
    logic [W-1:0] idx_w_s;

    // Walk offsets from farthest to nearest so the nearest valid port wins.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx_s         = 0;
        idx_w_s       = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx_s = int'(ptr_i) + off;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            idx_w_s = idx_s[W-1:0];
            if (valid_i[idx_w_s]) begin
                grant_o       = idx_w_s;
                grant_valid_o = 1'b1;
            end else begin
                grant_o       = grant_o;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between several requesters: round-robin grant, operand
// capture, and routing of the result back to the requester that issued it.
module alu_arbiter
    import calc_pkg::*;
#(
    parameter int NumRequesters = 2,
    parameter int ReqIdxW = $clog2(NumRequesters)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  num_t [NumRequesters-1:0]       req_left_i,
    input  num_t [NumRequesters-1:0]       req_right_i,
    input  op_t  [NumRequesters-1:0]       req_op_i,
    input  logic [NumRequesters-1:0]       req_in_valid_i,
    output logic [NumRequesters-1:0]       req_in_ready_o,
    output num_t                           req_result_o,
    output logic [NumRequesters-1:0]       req_out_valid_o,
    input  logic [NumRequesters-1:0]       req_out_ready_i,
    output num_t                           alu_left_o,
    output num_t                           alu_right_o,
    output op_t                            alu_op_o,
    output logic                           alu_in_valid_o,
    input  logic                           alu_in_ready_i,
    input  num_t                           alu_result_i,
    input  logic                           alu_out_valid_i,
    output logic                           alu_out_ready_o,
    output logic                           busy_o,
    output logic [ReqIdxW-1:0]             owner_o
);

    arb_state_e         state_q, state_d;
    logic [ReqIdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [ReqIdxW-1:0] owner_q, owner_d;
    num_t               left_q, left_d;
    num_t               right_q, right_d;
    op_t                op_q, op_d;

    logic [ReqIdxW-1:0] grant_s;
    logic               grant_valid_s;
    logic               grant_ok_s;

    rr_picker #(
        .N (NumRequesters),
        .W (ReqIdxW)
    ) u_rr_picker (
        .valid_i       (req_in_valid_i),
        .ptr_i         (rr_ptr_q),
        .grant_o       (grant_s),
        .grant_valid_o (grant_valid_s)
    );

    // Reset gating keeps every ready low while rst_ni is asserted.
    assign grant_ok_s = grant_valid_s && rst_ni && (state_q == ARB_IDLE);

    // Next-state: grant and capture in IDLE, ALU handshake in ISSUE, result handshake in WAIT.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        left_d   = left_q;
        right_d  = right_q;
        op_d     = op_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_ok_s) begin
                    owner_d = grant_s;
                    left_d  = req_left_i[grant_s];
                    right_d = req_right_i[grant_s];
                    op_d    = req_op_i[grant_s];
                    state_d = ARB_ISSUE;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (alu_in_ready_i) begin
                    state_d = ARB_WAIT;
                end else begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_WAIT: begin
                if (alu_out_valid_i && req_out_ready_i[owner_q]) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = ReqIdxW'(rr_next(32'(owner_q), 32'(NumRequesters)));
                end else begin
                    state_d = ARB_WAIT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, round-robin pointer, owner and captured operands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            op_q     <= OP_ADD;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            left_q   <= left_d;
            right_q  <= right_d;
            op_q     <= op_d;
        end
    end

    // Handshake steering: only the active phase drives its valid/ready lines.
    always_comb begin
        req_in_ready_o  = '0;
        req_out_valid_o = '0;
        req_result_o    = '0;
        alu_in_valid_o  = 1'b0;
        alu_out_ready_o = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_ok_s) begin
                    req_in_ready_o[grant_s] = 1'b1;
                end else begin
                    req_in_ready_o = '0;
                end
            end
            ARB_ISSUE: begin
                alu_in_valid_o = 1'b1;
            end
            ARB_WAIT: begin
                req_out_valid_o[owner_q] = alu_out_valid_i;
                alu_out_ready_o          = req_out_ready_i[owner_q];
                req_result_o             = alu_result_i;
            end
            default: begin
                alu_in_valid_o = 1'b0;
            end
        endcase
    end

    assign alu_left_o  = left_q;
    assign alu_right_o = right_q;
    assign alu_op_o    = op_q;
    assign busy_o      = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
    assign owner_o     = owner_q;

endmodule
